// File: rtl/sha_pkg.sv
// Shared definitions for the SHA message padder.
//   BLOCK_W       : width of one hash block in bits (512)
//   DEFAULT_LEN_W : default width of the appended message bit-length field
//   PAD_BYTE      : marker byte placed right after the last message byte
//   state_e       : padder FSM states
package sha_pkg;

    localparam int BLOCK_W       = 512;
    localparam int DEFAULT_LEN_W = 64;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        TAIL1 = 2'd2,
        TAIL2 = 2'd3
    } state_e;

endpackage

// File: rtl/sha_pad_tail.sv
// Combinational assembly of the final block(s) of a message.
// Ports:
//   data_i  : block buffer holding the message bytes, byte 0 in the MSBs
//   resid_i : number of valid message bytes in data_i (0..64)
//   len_i   : message length in bits (mod 2^LEN_W)
//   blk1_o  : first tail block (data, 0x80, zeros, length if it fits)
//   blk2_o  : second tail block (zeros and length, 0x80 first when resid_i==64)
//   two_o   : high when the length does not fit and blk2_o must be sent too
module sha_pad_tail
    import sha_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic [BLOCK_W-1:0] data_i,
    input  logic [6:0]         resid_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic [BLOCK_W-1:0] blk1_o,
    output logic [BLOCK_W-1:0] blk2_o,
    output logic               two_o
);

    logic [63:0] len64;

    always_comb begin
        len64  = 64'(len_i);
        two_o  = (resid_i >= 7'd56);
        blk1_o = '0;
        blk2_o = '0;

        // Bytes past the residual are rebuilt from zero, so stale buffer
        // content and discarded bytes of the last word never leak out.
        for (int i = 0; i < 64; i++) begin
            if (7'(i) < resid_i) begin
                blk1_o[BLOCK_W-1-8*i -: 8] = data_i[BLOCK_W-1-8*i -: 8];
            end else if (7'(i) == resid_i) begin
                blk1_o[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
            end
        end

        if (!two_o) begin
            blk1_o[63:0] = len64;
        end

        // A completely full data block pushes the marker into the next block.
        if (resid_i == 7'd64) begin
            blk2_o[BLOCK_W-1 -: 8] = PAD_BYTE;
        end
        blk2_o[63:0] = len64;
    end

endmodule

// File: rtl/sha_block_padder.sv
// SHA-1/SHA-2 style message padder: packs a stream of message words into
// 512-bit blocks, appends the 0x80 marker, zero fill and the big-endian
// message bit length, and hands blocks to a hash core with valid/ready.
// Optional feature macro: SHA_PAD_BLKCNT_EN adds blk_count.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready   : message word handshake
//   in_data             : message word, first byte in the MSBs
//   in_last, in_bytes   : final word flag and its valid byte count
//   blk_valid/blk_ready : block handshake towards the hash core
//   blk_data, blk_last  : 512-bit block, final-block flag
//   busy                : padder holds message state or a pending block
//   blk_count           : (SHA_PAD_BLKCNT_EN) blocks transferred since reset
module sha_block_padder
    import sha_pkg::*;
#(
    parameter int WORD_W = 32,  // 32 or 64
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W-1:0]             in_data,
    input  logic                          in_last,
    input  logic [$clog2(WORD_W/8):0]     in_bytes,
    output logic                          blk_valid,
    input  logic                          blk_ready,
    output logic [BLOCK_W-1:0]            blk_data,
    output logic                          blk_last,
    output logic                          busy
`ifdef SHA_PAD_BLKCNT_EN
    ,
    output logic [31:0]                   blk_count
`endif
);

    localparam int WB = WORD_W / 8;

    state_e               state_q;
    logic [6:0]           ptr_q;
    logic [LEN_W-1:0]     cnt_q;
    logic [BLOCK_W-1:0]   buf_q;
    logic [BLOCK_W-1:0]   blk_q;
    logic                 blk_last_q;
    logic                 blk_valid_q;
    logic                 in_ready_q;

    logic                 accept;
    logic [6:0]           nbytes;
    logic [WORD_W-1:0]    word_m;
    logic [BLOCK_W-1:0]   buf_d;
    logic [6:0]           resid;
    logic [LEN_W-1:0]     cnt_d;
    logic [LEN_W-1:0]     len_bits;
    logic [BLOCK_W-1:0]   tail1;
    logic [BLOCK_W-1:0]   tail2;
    logic                 two_blk;

    assign accept = in_valid && in_ready_q;

    always_comb begin
        // Bytes taken from this word; in_bytes beyond the word size saturates.
        nbytes = 7'(WB);
        if (in_last) begin
            nbytes = (7'(in_bytes) > 7'(WB)) ? 7'(WB) : 7'(in_bytes);
        end

        word_m = '0;
        for (int b = 0; b < WB; b++) begin
            if (b < int'(nbytes)) begin
                word_m[WORD_W-1-8*b -: 8] = in_data[WORD_W-1-8*b -: 8];
            end
        end

        // The pointer is always word aligned, so only whole-word slots exist.
        buf_d = buf_q;
        for (int k = 0; k < 64 / WB; k++) begin
            if (ptr_q == 7'(k * WB)) begin
                buf_d[BLOCK_W-1-k*WORD_W -: WORD_W] = word_m;
            end
        end

        resid    = ptr_q + nbytes;
        cnt_d    = cnt_q + LEN_W'(nbytes);
        len_bits = cnt_d << 3;
    end

    sha_pad_tail #(
        .LEN_W (LEN_W)
    ) u_tail (
        .data_i  (buf_d),
        .resid_i (resid),
        .len_i   (len_bits),
        .blk1_o  (tail1),
        .blk2_o  (tail2),
        .two_o   (two_blk)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FILL;
            ptr_q       <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            blk_q       <= '0;
            blk_last_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept && in_last) begin
                        // The buffer is free once the message ends, so it
                        // parks the second tail block until TAIL2.
                        cnt_q       <= cnt_d;
                        blk_q       <= tail1;
                        buf_q       <= tail2;
                        blk_last_q  <= !two_blk;
                        blk_valid_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state_q     <= TAIL1;
                    end else if (accept) begin
                        cnt_q <= cnt_d;
                        buf_q <= buf_d;
                        ptr_q <= ptr_q + 7'(WB);
                        if (ptr_q + 7'(WB) == 7'd64) begin
                            blk_q       <= buf_d;
                            blk_last_q  <= 1'b0;
                            blk_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= FULL;
                        end else begin
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (blk_ready) begin
                        ptr_q       <= '0;
                        blk_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                TAIL1: begin
                    if (blk_ready) begin
                        if (blk_last_q) begin
                            ptr_q       <= '0;
                            cnt_q       <= '0;
                            blk_last_q  <= 1'b0;
                            blk_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= FILL;
                        end else begin
                            blk_q      <= buf_q;
                            blk_last_q <= 1'b1;
                            state_q    <= TAIL2;
                        end
                    end
                end
                TAIL2: begin
                    if (blk_ready) begin
                        ptr_q       <= '0;
                        cnt_q       <= '0;
                        blk_last_q  <= 1'b0;
                        blk_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= FILL;
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_data  = blk_q;
    assign blk_last  = blk_last_q;
    assign busy      = !((state_q == FILL) && (ptr_q == 7'd0));

`ifdef SHA_PAD_BLKCNT_EN
    logic [31:0] blk_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_count_q <= '0;
        end else if (blk_valid_q && blk_ready) begin
            blk_count_q <= blk_count_q + 32'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_sha_block_padder.sv
module tb_sha_block_padder;

    localparam logic [511:0] B64 = 512'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f_20212223_24252627_28292a2b_2c2d2e2f_30313233_34353637_38393a3b_3c3d3e3f;
    localparam logic [511:0] B56 = 512'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f_20212223_24252627_28292a2b_2c2d2e2f_30313233_34353637_80000000_00000000;
    localparam logic [511:0] ABC   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] EMPTY = {8'h80, 504'h0};
    localparam logic [511:0] L56B2 = 512'h1C0;
    localparam logic [511:0] L64B2 = {8'h80, 440'h0, 64'h200};
    localparam logic [511:0] HELLO = {64'h68656c6c6f800000, 384'h0, 64'h28};
    localparam logic [511:0] L67B2 = {32'h61626380, 416'h0, 64'h218};

    logic         clk = 1'b0;
    logic         reset = 1'b0;

    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         in_last = 1'b0;
    logic [2:0]   in_bytes = '0;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         busy;

    logic         in_valid64 = 1'b0;
    logic         in_ready64;
    logic [63:0]  in_data64 = '0;
    logic         in_last64 = 1'b0;
    logic [3:0]   in_bytes64 = '0;
    logic         blk_valid64;
    logic         blk_ready64 = 1'b1;
    logic [511:0] blk_data64;
    logic         blk_last64;
    logic         busy64;

`ifdef SHA_PAD_BLKCNT_EN
    logic [31:0]  blk_count;
    logic [31:0]  blk_count64;
`endif

    int checks = 0;
    int fails  = 0;

    logic [512:0] exp_q[$];
    logic [512:0] exp64_q[$];

    always #5 clk = ~clk;

    sha_block_padder #(.WORD_W(32), .LEN_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .busy      (busy)
`ifdef SHA_PAD_BLKCNT_EN
        ,
        .blk_count (blk_count)
`endif
    );

    sha_block_padder #(.WORD_W(64), .LEN_W(64)) dut64 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .in_data   (in_data64),
        .in_last   (in_last64),
        .in_bytes  (in_bytes64),
        .blk_valid (blk_valid64),
        .blk_ready (blk_ready64),
        .blk_data  (blk_data64),
        .blk_last  (blk_last64),
        .busy      (busy64)
`ifdef SHA_PAD_BLKCNT_EN
        ,
        .blk_count (blk_count64)
`endif
    );

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_blk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitors: one pop per transferred block.
    always @(negedge clk) begin
        if (reset && blk_valid && blk_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL blk32_unexpected: got %h last %b, no block expected", blk_data, blk_last);
            end else begin
                logic [512:0] e;
                e = exp_q.pop_front();
                if ({blk_last, blk_data} !== e) begin
                    fails++;
                    $display("FAIL blk32: got last=%b %h expected last=%b %h", blk_last, blk_data, e[512], e[511:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset && blk_valid64 && blk_ready64) begin
            checks++;
            if (exp64_q.size() == 0) begin
                fails++;
                $display("FAIL blk64_unexpected: got %h last %b, no block expected", blk_data64, blk_last64);
            end else begin
                logic [512:0] e;
                e = exp64_q.pop_front();
                if ({blk_last64, blk_data64} !== e) begin
                    fails++;
                    $display("FAIL blk64: got last=%b %h expected last=%b %h", blk_last64, blk_data64, e[512], e[511:0]);
                end
            end
        end
    end

    function automatic logic [31:0] pat32(input int k);
        return {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
    endfunction

    function automatic logic [63:0] pat64(input int k);
        return {pat32(2*k), pat32(2*k+1)};
    endfunction

    task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = nb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (l) begin
            @(negedge clk);
            check1("block_latency", blk_valid, 1'b1);
        end
    endtask

    task automatic send_word64(input logic [63:0] d, input logic l, input logic [3:0] nb);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready64 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready64) begin
            checks++;
            fails++;
            $display("FAIL in_ready64_timeout: in_ready=%b required 1", in_ready64);
        end
        in_valid64 = 1'b1;
        in_data64  = d;
        in_last64  = l;
        in_bytes64 = nb;
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        in_last64  = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(in_ready && !busy && exp_q.size() == 0 && in_ready64 && !busy64 && exp64_q.size() == 0)
               && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 500) begin
            fails++;
            $display("FAIL idle_timeout: busy=%b pending=%0d expected busy=0 pending=0", busy, exp_q.size());
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_blk_valid", blk_valid, 1'b0);
        check1("rst_blk_last", blk_last, 1'b0);
        check1("rst_busy", busy, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check1("post_rst_in_ready", in_ready, 1'b1);

        // "abc"
        exp_q.push_back({1'b1, ABC});
        send_word(32'h61626300, 1'b1, 3'd3);
        wait_idle();

        // Empty message
        exp_q.push_back({1'b1, EMPTY});
        send_word(32'h0, 1'b1, 3'd0);
        wait_idle();

        // 56 bytes: length spills into a second block
        exp_q.push_back({1'b0, B56});
        exp_q.push_back({1'b1, L56B2});
        for (int k = 0; k < 14; k++) send_word(pat32(k), k == 13, 3'd4);
        wait_idle();

        // 64 bytes: marker moves to the second block
        exp_q.push_back({1'b0, B64});
        exp_q.push_back({1'b1, L64B2});
        for (int k = 0; k < 16; k++) send_word(pat32(k), k == 15, 3'd4);
        wait_idle();

        // 67 bytes: full block through FULL, then "abc" tail with running count
        exp_q.push_back({1'b0, B64});
        exp_q.push_back({1'b1, L67B2});
        for (int k = 0; k < 16; k++) send_word(pat32(k), 1'b0, 3'd4);
        send_word(32'h616263EE, 1'b1, 3'd3);
        wait_idle();

        // "hello" with junk after the last valid byte
        exp_q.push_back({1'b1, HELLO});
        send_word(32'h68656c6c, 1'b0, 3'd4);
        send_word(32'h6fAABBCC, 1'b1, 3'd1);
        wait_idle();

        // "abc" with junk byte
        exp_q.push_back({1'b1, ABC});
        send_word(32'h616263FF, 1'b1, 3'd3);
        wait_idle();

        // Back-pressure: block held for 5 cycles
        blk_ready = 1'b0;
        exp_q.push_back({1'b1, ABC});
        send_word(32'h61626300, 1'b1, 3'd3);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            check1("stall_valid", blk_valid, 1'b1);
            check1("stall_in_ready", in_ready, 1'b0);
            check1("stall_last", blk_last, 1'b1);
            check_blk("stall_data", blk_data, ABC);
        end
        @(posedge clk);
        #1;
        blk_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check1("stall_released", blk_valid, 1'b0);
        @(negedge clk);
        check1("stall_in_ready_back", in_ready, 1'b1);
        wait_idle();

        // Mid-message reset after 7 words
        for (int k = 0; k < 7; k++) send_word(pat32(k), 1'b0, 3'd4);
        @(negedge clk);
        check1("mid_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check1("mid_rst_busy", busy, 1'b0);
        check1("mid_rst_blk_valid", blk_valid, 1'b0);
        check1("mid_rst_in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_q.push_back({1'b1, ABC});
        send_word(32'h61626300, 1'b1, 3'd3);
        wait_idle();

        // 64-bit word instance
        exp64_q.push_back({1'b0, B64});
        exp64_q.push_back({1'b1, L64B2});
        for (int k = 0; k < 8; k++) send_word64(pat64(k), k == 7, 4'd8);
        wait_idle();
        exp64_q.push_back({1'b1, ABC});
        send_word64(64'h616263DEADBEEF55, 1'b1, 4'd3);
        wait_idle();

        checks++;
        if (exp_q.size() != 0 || exp64_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: pending %0d/%0d required 0/0", exp_q.size(), exp64_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exceeded, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
